// File: rtl/acq_pkg.sv
// Shared types and widths for the ADC-to-AXI-Stream acquisition sequencer.
package acq_pkg;

    localparam int ACQ_SAMPLE_W = 16;
    localparam int BEAT_W       = 2 * ACQ_SAMPLE_W;
    localparam int KEEP_W       = BEAT_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAD   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } acq_state_t;

    // A packet length is rejected when it is zero or not a whole number of beats.
    function automatic logic len_bad(input logic nonzero, input logic [1:0] lsbs);
        return (!nonzero) || (lsbs != 2'b00);
    endfunction

endpackage

// File: rtl/acq_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is accepted
// when a pop happens in the same cycle, because the pop frees the slot.
module acq_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rd_en_s = pop_i && !empty_o;
    assign wr_en_s = push_i && (!full_o || rd_en_s);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage array; contents need no reset since empty_o masks them.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/acq_stream_ctrl.sv
// Acquisition sequencer: packs ADC sample pairs into stream beats, frames one
// packet per start and reports status to the register block.
module acq_stream_ctrl
    import acq_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 26
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic [LEN_W-1:0]        cfg_pkt_bytes,
    input  logic                    adc_valid,
    input  logic [SAMPLE_W-1:0]     adc_data,
    output logic [2*SAMPLE_W-1:0]   m_axis_tdata,
    output logic [2*SAMPLE_W/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    sts_busy,
    output logic                    sts_done,
    output logic                    sts_overflow,
    output logic                    sts_aborted,
    output logic                    sts_cfg_err,
    output logic [LEN_W-3:0]        sts_words_sent
);

    localparam int BW = 2 * SAMPLE_W;
    localparam int KW = BW / 8;
    localparam int CW = LEN_W - 2;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW:0] DEPTH_L = (LW + 1)'(FIFO_DEPTH);

    acq_state_t          state_q, state_d;
    logic [CW-1:0]       words_total_q, words_total_d;
    logic [CW-1:0]       words_pushed_q, words_pushed_d;
    logic [CW-1:0]       words_sent_q, words_sent_d;
    logic                phase_q, phase_d;
    logic [SAMPLE_W-1:0] half_q, half_d;
    logic                push_q, push_d;
    logic [BW-1:0]       word_q, word_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                abort_q, abort_d;
    logic                cfg_err_q, cfg_err_d;
    logic                busy_q, busy_d;

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [BW-1:0]       fifo_head_s;
    logic [LW-1:0]       fifo_level_s;
    logic                pop_s;
    logic                push_ok_s;
    logic                room_s;
    logic                pad_space_s;
    logic                start_s;

    acq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BW)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push_q),
        .din_i   (word_q),
        .pop_i   (pop_s),
        .dout_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level_s)
    );

    assign pop_s     = (!fifo_empty_s) && m_axis_tready;
    assign push_ok_s = push_q && ((!fifo_full_s) || pop_s);
    assign start_s   = cfg_start && !cfg_stop;

    // The word waiting in the push register already counts toward the packet,
    // so no new word is formed once pushed + pending reaches the total.
    assign room_s      = ({1'b0, words_pushed_q} + {{CW{1'b0}}, push_q}) < {1'b0, words_total_q};
    assign pad_space_s = ({1'b0, fifo_level_s} + {{LW{1'b0}}, push_q}) < DEPTH_L;

    assign m_axis_tvalid  = !fifo_empty_s;
    assign m_axis_tdata   = fifo_empty_s ? '0 : fifo_head_s;
    assign m_axis_tkeep   = {KW{1'b1}};
    assign m_axis_tlast   = m_axis_tvalid && (words_sent_q == (words_total_q - 1'b1));
    assign sts_busy       = busy_q;
    assign sts_done       = done_q;
    assign sts_overflow   = ovf_q;
    assign sts_aborted    = abort_q;
    assign sts_cfg_err    = cfg_err_q;
    assign sts_words_sent = words_sent_q;

    // Next-state logic for sequencing, packing, counters and sticky status.
    always_comb begin
        state_d        = state_q;
        words_total_d  = words_total_q;
        words_pushed_d = words_pushed_q;
        words_sent_d   = words_sent_q;
        phase_d        = phase_q;
        half_d         = half_q;
        push_d         = 1'b0;
        word_d         = word_q;
        done_d         = done_q;
        ovf_d          = ovf_q;
        abort_d        = abort_q;
        cfg_err_d      = cfg_err_q;

        if (push_ok_s) begin
            words_pushed_d = words_pushed_q + 1'b1;
        end else if (push_q) begin
            ovf_d = 1'b1;
        end else begin
            words_pushed_d = words_pushed_q;
        end

        if (pop_s) begin
            words_sent_d = words_sent_q + 1'b1;
        end else begin
            words_sent_d = words_sent_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    done_d         = 1'b0;
                    ovf_d          = 1'b0;
                    abort_d        = 1'b0;
                    words_pushed_d = '0;
                    words_sent_d   = '0;
                    phase_d        = 1'b0;
                    if (len_bad(|cfg_pkt_bytes, cfg_pkt_bytes[1:0])) begin
                        cfg_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cfg_err_d     = 1'b0;
                        words_total_d = cfg_pkt_bytes[LEN_W-1:2];
                        state_d       = ST_RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                // An abort landing on the final push has nothing left to pad.
                if (cfg_stop) begin
                    phase_d = 1'b0;
                    abort_d = 1'b1;
                    state_d = (words_pushed_d == words_total_q) ? ST_DRAIN : ST_PAD;
                end else if (words_pushed_d == words_total_q) begin
                    state_d = ST_DRAIN;
                end else if (adc_valid && room_s) begin
                    if (!phase_q) begin
                        half_d  = adc_data;
                        phase_d = 1'b1;
                    end else begin
                        word_d  = {adc_data, half_q};
                        push_d  = 1'b1;
                        phase_d = 1'b0;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAD: begin
                if (words_pushed_d == words_total_q) begin
                    state_d = ST_DRAIN;
                end else if (room_s && pad_space_s) begin
                    word_d = '0;
                    push_d = 1'b1;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_DRAIN: begin
                if (pop_s && m_axis_tlast) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAD) || (state_d == ST_DRAIN);
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            words_total_q  <= '0;
            words_pushed_q <= '0;
            words_sent_q   <= '0;
            phase_q        <= 1'b0;
            half_q         <= '0;
            push_q         <= 1'b0;
            word_q         <= '0;
            done_q         <= 1'b0;
            ovf_q          <= 1'b0;
            abort_q        <= 1'b0;
            cfg_err_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            words_total_q  <= words_total_d;
            words_pushed_q <= words_pushed_d;
            words_sent_q   <= words_sent_d;
            phase_q        <= phase_d;
            half_q         <= half_d;
            push_q         <= push_d;
            word_q         <= word_d;
            done_q         <= done_d;
            ovf_q          <= ovf_d;
            abort_q        <= abort_d;
            cfg_err_q      <= cfg_err_d;
            busy_q         <= busy_d;
        end
    end

endmodule

// File: tb/tb_acq_stream_ctrl.sv
// Scoreboard bench for acq_stream_ctrl: expected beats are derived from the
// driven sample list and checked by an independent stream monitor.
module tb_acq_stream_ctrl;

    localparam int SW    = 16;
    localparam int DEPTH = 16;
    localparam int LW    = 26;
    localparam int CW    = LW - 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic              cfg_start;
    logic              cfg_stop;
    logic [LW-1:0]     cfg_pkt_bytes;
    logic              adc_valid;
    logic [SW-1:0]     adc_data;
    logic [2*SW-1:0]   m_axis_tdata;
    logic [2*SW/8-1:0] m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic              sts_busy;
    logic              sts_done;
    logic              sts_overflow;
    logic              sts_aborted;
    logic              sts_cfg_err;
    logic [CW-1:0]     sts_words_sent;

    always #5 clk = ~clk;

    acq_stream_ctrl #(
        .SAMPLE_W   (SW),
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (LW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_pkt_bytes  (cfg_pkt_bytes),
        .adc_valid      (adc_valid),
        .adc_data       (adc_data),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .sts_busy       (sts_busy),
        .sts_done       (sts_done),
        .sts_overflow   (sts_overflow),
        .sts_aborted    (sts_aborted),
        .sts_cfg_err    (sts_cfg_err),
        .sts_words_sent (sts_words_sent)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        chk;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] smp_q[$];
    int          n_chk   = 0;
    int          n_bad   = 0;
    int          rdy_pct = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: beat i carries samples 2i (low) and 2i+1 (high); any beat
    // without a complete sample pair (abort) is zero; the final beat has tlast.
    task automatic load_exp(input int nw, input bit cd);
        exp_t e;
        for (int i = 0; i < nw; i++) begin
            if (2 * i + 1 < smp_q.size()) e.data = {smp_q[2*i+1], smp_q[2*i]};
            else e.data = 32'h0;
            e.last = (i == nw - 1);
            e.chk  = cd;
            exp_q.push_back(e);
        end
    endtask

    task automatic gen_samples(input int n, input int mode);
        smp_q.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       smp_q.push_back((i % 2 == 0) ? 16'h00FF : 16'hFF00);
                2:       smp_q.push_back(16'(i + 1));
                default: smp_q.push_back(16'($urandom));
            endcase
        end
    endtask

    task automatic start_pkt(input int bytes);
        cfg_pkt_bytes = LW'(bytes);
        cfg_start     = 1'b1;
        cyc(1);
        cfg_start     = 1'b0;
    endtask

    task automatic drive(input int from, input int to, input int gmin, input int gmax, input bit lat);
        for (int i = from; i < to; i++) begin
            if (lat && i == 2) chk("latency_not_yet", 32'(m_axis_tvalid), 32'd0);
            if (lat && i == 3) chk("latency_2cyc", 32'(m_axis_tvalid), 32'd1);
            adc_valid = 1'b1;
            adc_data  = smp_q[i];
            cyc(1);
            adc_valid = 1'b0;
            cyc($urandom_range(gmax, gmin));
        end
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!(sts_done && exp_q.size() == 0) && t < 4000) begin
            cyc(1);
            t++;
        end
        chk({name, "_complete"}, 32'(t < 4000), 32'd1);
    endtask

    task automatic end_chk(input string name, input int nw, input bit ovf, input bit ab);
        cyc(2);
        chk({name, "_words_sent"}, 32'(sts_words_sent), 32'(nw));
        chk({name, "_overflow"}, 32'(sts_overflow), 32'(ovf));
        chk({name, "_aborted"}, 32'(sts_aborted), 32'(ab));
        chk({name, "_busy"}, 32'(sts_busy), 32'd0);
        chk({name, "_done"}, 32'(sts_done), 32'd1);
        chk({name, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    endtask

    // Ready generator with a programmable duty.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Stream monitor: compares every handshaken beat against the scoreboard
    // and checks that a stalled beat stays put.
    initial begin
        exp_t        e;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (prev_stall) begin
                    chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
                    chk("stall_tdata", m_axis_tdata, prev_data);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("beat_tlast", 32'(m_axis_tlast), 32'(e.last));
                        if (e.chk) chk("beat_tdata", m_axis_tdata, e.data);
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nw;
        resetn        = 1'b0;
        cfg_start     = 1'b0;
        cfg_stop      = 1'b0;
        cfg_pkt_bytes = '0;
        adc_valid     = 1'b0;
        adc_data      = '0;
        cyc(3);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tkeep", 32'(m_axis_tkeep), 32'hF);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_tdata", m_axis_tdata, 32'd0);
        chk("rst_busy", 32'(sts_busy), 32'd0);
        chk("rst_flags", 32'({sts_done, sts_overflow, sts_aborted, sts_cfg_err}), 32'd0);
        chk("rst_words", 32'(sts_words_sent), 32'd0);
        resetn = 1'b1;
        cyc(2);

        // 2048-byte packet of alternating samples, always ready
        rdy_pct = 100;
        start_pkt(2048);
        chk("t1_busy", 32'(sts_busy), 32'd1);
        gen_samples(1024, 1);
        load_exp(512, 1'b1);
        drive(0, 1024, 0, 0, 1'b1);
        wait_done("t1");
        end_chk("t1", 512, 1'b0, 1'b0);

        // ready held low while samples stream every cycle: words get dropped
        rdy_pct = 0;
        start_pkt(128);
        for (int i = 0; i < 32; i++) exp_q.push_back('{data: 32'h0, last: (i == 31), chk: 1'b0});
        for (int c = 0; c < 300; c++) begin
            if (c == 40) rdy_pct = 100;
            adc_valid = 1'b1;
            adc_data  = 16'($urandom);
            cyc(1);
        end
        adc_valid = 1'b0;
        wait_done("t2_ovf");
        end_chk("t2_ovf", 32, 1'b1, 1'b0);

        // sparse samples with 50% ready: nothing dropped
        rdy_pct = 50;
        start_pkt(64);
        gen_samples(32, 0);
        load_exp(16, 1'b1);
        drive(0, 32, 3, 3, 1'b0);
        wait_done("t2_slow");
        end_chk("t2_slow", 16, 1'b0, 1'b0);

        // illegal lengths
        start_pkt(6);
        chk("len6_cfg_err", 32'(sts_cfg_err), 32'd1);
        chk("len6_done_cleared", 32'(sts_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("len6_busy", 32'(sts_busy), 32'd0);
            chk("len6_tvalid", 32'(m_axis_tvalid), 32'd0);
            cyc(1);
        end
        start_pkt(0);
        chk("len0_cfg_err", 32'(sts_cfg_err), 32'd1);
        cyc(2);
        chk("len0_busy", 32'(sts_busy), 32'd0);
        chk("len0_tvalid", 32'(m_axis_tvalid), 32'd0);

        // abort after 10 words with a dangling half sample
        rdy_pct = 60;
        start_pkt(64);
        chk("abort_cfg_err_cleared", 32'(sts_cfg_err), 32'd0);
        gen_samples(21, 2);
        load_exp(16, 1'b1);
        drive(0, 21, 0, 1, 1'b0);
        cyc(4);
        cfg_stop = 1'b1;
        cyc(1);
        cfg_stop = 1'b0;
        chk("abort_flag", 32'(sts_aborted), 32'd1);
        wait_done("t4_abort");
        end_chk("t4_abort", 16, 1'b0, 1'b1);

        // reset mid-packet with 5 words queued
        rdy_pct = 0;
        start_pkt(64);
        gen_samples(10, 0);
        load_exp(16, 1'b1);
        drive(0, 10, 0, 0, 1'b0);
        cyc(3);
        chk("t5_queued", 32'(m_axis_tvalid), 32'd1);
        resetn = 1'b0;
        cyc(1);
        chk("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t5_busy", 32'(sts_busy), 32'd0);
        chk("t5_words", 32'(sts_words_sent), 32'd0);
        resetn = 1'b1;
        exp_q.delete();
        rdy_pct = 80;
        start_pkt(40);
        gen_samples(20, 0);
        load_exp(10, 1'b1);
        drive(0, 20, 0, 2, 1'b0);
        wait_done("t5_restart");
        end_chk("t5_restart", 10, 1'b0, 1'b0);

        // start with stop together, and a second start mid-packet
        cfg_pkt_bytes = LW'(64);
        cfg_start     = 1'b1;
        cfg_stop      = 1'b1;
        cyc(1);
        cfg_start     = 1'b0;
        cfg_stop      = 1'b0;
        cyc(1);
        chk("t6_startstop_busy", 32'(sts_busy), 32'd0);
        chk("t6_startstop_done", 32'(sts_done), 32'd1);
        start_pkt(64);
        gen_samples(34, 0);
        load_exp(16, 1'b1);
        drive(0, 16, 0, 1, 1'b0);
        start_pkt(8);
        chk("t6_restart_busy", 32'(sts_busy), 32'd1);
        drive(16, 34, 0, 1, 1'b0);
        wait_done("t6");
        end_chk("t6", 16, 1'b0, 1'b0);

        // random packets
        for (int p = 0; p < 6; p++) begin
            nw      = $urandom_range(64, 1);
            rdy_pct = $urandom_range(100, 70);
            start_pkt(nw * 4);
            gen_samples(2 * nw + $urandom_range(3), 0);
            load_exp(nw, 1'b1);
            drive(0, smp_q.size(), 0, 2, 1'b0);
            wait_done("rand");
            end_chk("rand", nw, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/acq_stream_ctrl.md
Name: acq_stream_ctrl

Overview:
Acquisition sequencer between the ADC sample capture path and the AXI DMA S2MM stream port. It is armed by the register block (start / stop / packet size). It packs 16-bit ADC samples into 32-bit AXI-Stream beats, frames exactly one packet per start with TLAST on the final beat, and buffers against DMA backpressure in a small FIFO. It reports busy/done/overflow/error status back to the register block.

Parameters:
SAMPLE_W, 16, ADC sample width; the output beat holds two samples.
FIFO_DEPTH, 16, packed-word FIFO depth; must be a power of 2 and at least 4.
LEN_W, 26, width of the packet byte-count register (max 64 MiB - 4).

Ports:
clk  in  1  system clock; all logic on rising edge.
resetn  in  1  synchronous, active-low reset.
cfg_start  in  1  one-cycle start pulse from register block.
cfg_stop  in  1  one-cycle abort pulse.
cfg_pkt_bytes  in  LEN_W  packet length in bytes; sampled on start.
adc_valid  in  1  sample strobe, already in the clk domain.
adc_data  in  SAMPLE_W  sample value.
m_axis_tdata  out  2*SAMPLE_W  stream data.
m_axis_tkeep  out  2*SAMPLE_W/8  always all ones.
m_axis_tvalid  out  1  stream valid.
m_axis_tlast  out  1  last beat of packet.
m_axis_tready  in  1  DMA ready.
sts_busy  out  1  high in RUN, PAD, DRAIN.
sts_done  out  1  sticky; packet fully transferred.
sts_overflow  out  1  sticky; a word was dropped because the FIFO was full.
sts_aborted  out  1  sticky; packet ended by cfg_stop.
sts_cfg_err  out  1  sticky; bad length at start.
sts_words_sent  out  LEN_W-2  beats handshaken in the current packet.

Behaviour:
- Reset: all outputs 0 except m_axis_tkeep (all ones). State IDLE. FIFO empty. Counters 0. Pack half-register cleared. Reset mid-packet has the same effect; tvalid drops the cycle after resetn low.
- States: IDLE, RUN, PAD, DRAIN, DONE.
- Start in IDLE or DONE:
  - Clears all sticky status and counters.
  - If cfg_pkt_bytes == 0 or cfg_pkt_bytes[1:0] != 0: set sts_cfg_err, stay IDLE.
  - Otherwise latch words_total = cfg_pkt_bytes >> 2 and enter RUN next cycle.
  - Start in RUN, PAD or DRAIN is ignored.
- RUN:
  - Each adc_valid alternates pack phase. First sample goes to tdata[15:0]; the second forms the word {second, first} and requests a FIFO push.
  - Push succeeds if the FIFO is not full: words_pushed++. If full: word dropped, sts_overflow set, words_pushed unchanged, phase still resets.
  - When words_pushed reaches words_total: enter DRAIN and ignore further samples.
- Abort: cfg_stop in RUN discards any half-packed sample, sets sts_aborted and enters PAD.
- PAD: pushes 0x0000_0000 words (one per cycle when not full) until words_pushed == words_total, then enters DRAIN. The DMA always receives a full-length packet.
- cfg_stop in IDLE, DRAIN or DONE: no effect. cfg_start and cfg_stop in the same cycle: stop wins; start ignored.
- Output side, independent of state:
  - tvalid = FIFO not empty; tdata = FIFO head (first-word-fall-through).
  - tlast = tvalid && (sts_words_sent == words_total - 1).
  - On tvalid && tready: pop and increment sts_words_sent.
  - tvalid and tdata hold stable while tready is low (AXIS rule).
- DRAIN: on the handshake of the tlast beat, go to DONE and set sts_done the next cycle. DONE behaves as IDLE for start.
- Latency: a pair-completing sample is visible on tvalid 2 cycles later, given an empty FIFO (push register + FIFO).
- Simultaneous FIFO push and pop when full: the push is allowed because the pop frees a slot.
- Counter widths: words_pushed and sts_words_sent are LEN_W-2 bits; no wrap is possible by construction.

Decomposition:
- Package acq_pkg: typedef acq_state_t (enum of the 5 states); localparams BEAT_W = 2*SAMPLE_W and KEEP_W.
- One sub-module, acq_fifo: synchronous FWFT FIFO. Parameters DEPTH and WIDTH; ports push, pop, full, empty. It is reused for the push/pop-when-full rule.

Test Plan:
1. Samples alternating 0x00FF, 0xFF00 every cycle, pkt_bytes = 2048, tready = 1 -> 512 beats, each 0xFF0000FF; tlast only on beat 511; sts_done = 1; sts_overflow = 0.
2. pkt_bytes = 64, adc_valid every cycle, tready low for 40 cycles, FIFO_DEPTH = 16 -> sts_overflow = 1; exactly 16 beats still delivered with tlast on the 16th. Repeating with adc_valid every 4th cycle and tready 50% gives overflow 0.
3. pkt_bytes = 6, then pkt_bytes = 0 -> sts_cfg_err = 1 each time, no tvalid, sts_busy stays 0.
4. pkt_bytes = 64 with incrementing samples, cfg_stop after the 10th pushed word -> 16 beats total; beats 10-15 are 0x00000000; tlast on beat 15; sts_aborted = 1 and sts_done = 1.
5. resetn low for 1 cycle mid-RUN with 5 words queued and tready = 0 -> next cycle tvalid = 0, sts_busy = 0, sts_words_sent = 0; a new start runs cleanly.
6. cfg_start pulsed again during RUN, and start together with stop in IDLE -> no restart, no state change; the packet completes normally.
